// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a shared combinational integer ALU.
// S1 holds the granted operation and drives the ALU bus; S2 holds the captured result.
module alu_issue_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_opcode,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  input  logic [11:0]      req0_imm,
  input  logic [4:0]       req0_shamt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_opcode,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  input  logic [11:0]      req1_imm,
  input  logic [4:0]       req1_shamt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             alu_rst,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [11:0]      alu_imm,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src
);

  logic             s1_v_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic             s1_src_r;
  logic             last_r;
  logic             lock_r;
  logic             lock_idx_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             can_accept_s;
  logic             any_req_s;
  logic             grant_s;
  logic             accept_s;

  logic [6:0]       sel_opcode_s;
  logic [2:0]       sel_funct3_s;
  logic [6:0]       sel_funct7_s;
  logic [WIDTH-1:0] sel_rs1_s;
  logic [WIDTH-1:0] sel_rs2_s;
  logic [11:0]      sel_imm_s;
  logic [4:0]       sel_shamt_s;
  logic [TAG_W-1:0] sel_tag_s;

  assign alu_rst = ~rst_n;

  // Pipeline advance and S1 availability.
  always_comb begin
    s2_adv_s     = ~rsp_valid | rsp_ready;
    s1_adv_s     = s2_adv_s;
    can_accept_s = ~s1_v_r | s1_adv_s;
  end

  // Round-robin grant; a stalled grant stays locked until its handshake completes.
  always_comb begin
    any_req_s = req0_valid | req1_valid;
    if (lock_r) begin
      grant_s = lock_idx_r;
    end else if (req0_valid & req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Ready only toward the granted, valid requester and never while in reset.
  always_comb begin
    req0_ready = rst_n & can_accept_s & ~grant_s & req0_valid;
    req1_ready = rst_n & can_accept_s & grant_s & req1_valid;
    accept_s   = req0_ready | req1_ready;
  end

  // Payload select for the granted requester.
  always_comb begin
    case (grant_s)
      1'b1: begin
        sel_opcode_s = req1_opcode;
        sel_funct3_s = req1_funct3;
        sel_funct7_s = req1_funct7;
        sel_rs1_s    = req1_rs1;
        sel_rs2_s    = req1_rs2;
        sel_imm_s    = req1_imm;
        sel_shamt_s  = req1_shamt;
        sel_tag_s    = req1_tag;
      end
      default: begin
        sel_opcode_s = req0_opcode;
        sel_funct3_s = req0_funct3;
        sel_funct7_s = req0_funct7;
        sel_rs1_s    = req0_rs1;
        sel_rs2_s    = req0_rs2;
        sel_imm_s    = req0_imm;
        sel_shamt_s  = req0_shamt;
        sel_tag_s    = req0_tag;
      end
    endcase
  end

  // Arbitration state: last winner and grant lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r     <= 1'b1;
      lock_r     <= 1'b0;
      lock_idx_r <= 1'b0;
    end else begin
      if (accept_s) begin
        last_r <= grant_s;
      end
      lock_r     <= any_req_s & ~accept_s;
      lock_idx_r <= grant_s;
    end
  end

  // S1 operand stage; cleared fields keep the ALU bus at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r     <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
      s1_src_r   <= 1'b0;
      alu_opcode <= 7'h00;
      alu_funct3 <= 3'h0;
      alu_funct7 <= 7'h00;
      alu_rs1    <= {WIDTH{1'b0}};
      alu_rs2    <= {WIDTH{1'b0}};
      alu_imm    <= 12'h000;
      alu_shamt  <= 5'h00;
    end else if (accept_s) begin
      s1_v_r     <= 1'b1;
      s1_tag_r   <= sel_tag_s;
      s1_src_r   <= grant_s;
      alu_opcode <= sel_opcode_s;
      alu_funct3 <= sel_funct3_s;
      alu_funct7 <= sel_funct7_s;
      alu_rs1    <= sel_rs1_s;
      alu_rs2    <= sel_rs2_s;
      alu_imm    <= sel_imm_s;
      alu_shamt  <= sel_shamt_s;
    end else if (s1_adv_s) begin
      s1_v_r     <= 1'b0;
      s1_tag_r   <= {TAG_W{1'b0}};
      s1_src_r   <= 1'b0;
      alu_opcode <= 7'h00;
      alu_funct3 <= 3'h0;
      alu_funct7 <= 7'h00;
      alu_rs1    <= {WIDTH{1'b0}};
      alu_rs2    <= {WIDTH{1'b0}};
      alu_imm    <= 12'h000;
      alu_shamt  <= 5'h00;
    end
  end

  // S2 response stage captures the ALU result alongside tag and source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= {WIDTH{1'b0}};
      rsp_tag   <= {TAG_W{1'b0}};
      rsp_src   <= 1'b0;
    end else if (s1_v_r & s2_adv_s) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_rd;
      rsp_tag   <= s1_tag_r;
      rsp_src   <= s1_src_r;
    end else if (s2_adv_s) begin
      rsp_valid <= 1'b0;
    end
  end

  alu_issue_arbiter_chk #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_src    (rsp_src)
  );

endmodule

// Protocol properties for the issue handshakes and response hold under backpressure.
module alu_issue_arbiter_chk #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req0_valid,
  input logic             req0_ready,
  input logic             req1_valid,
  input logic             req1_ready,
  input logic             rsp_valid,
  input logic             rsp_ready,
  input logic [WIDTH-1:0] rsp_data,
  input logic [TAG_W-1:0] rsp_tag,
  input logic             rsp_src
);

  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    (!req0_ready || req0_valid) && (!req1_ready || req1_valid));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_tag) && $stable(rsp_src)));

endmodule
